cajero_parametrizado: RTL and testbench
=======================================

// Module: cajero_parametrizado
// PURPOSE
//  Parametrised next-generation ATM transaction controller: configurable PIN length, attempt limit,
//  balance/amount widths and inactivity timeout. Collects BCD PIN digits and verifies the PIN with
//  in-session retries. Keeps a failed-attempt count that persists across card sessions. Then runs
//  one deposit/withdrawal with overflow and insufficient-funds checks and outputs the new balance.
// PARAMETERS
//  N_DIGITOS      4     PIN length in BCD digits (>=1)
//  MAX_INTENTOS   3     consecutive failures that lock the machine (>=2)
//  BAL_W          64    balance width
//  MONTO_W        32    amount width (MONTO_W <= BAL_W)
//  TIMEOUT_CICLOS 1024  idle cycles allowed in PIN entry / amount wait before abort
// PORTS
//  clock                in   1              system clock, rising edge
//  reset                in   1              asynchronous, active-high
//  tarjeta_recibida     in   1              card inserted (sampled in IDLE only)
//  tipo_trans           in   1              0=deposito, 1=retiro; sampled with monto_stb
//  digito_stb           in   1              digito valid this cycle
//  digito               in   4              BCD digit
//  pin                  in   4*N_DIGITOS    stored PIN, first digit in MS nibble
//  balance_inicial      in   BAL_W          account balance, latched at card acceptance
//  monto                in   MONTO_W        transaction amount, zero-extended to BAL_W
//  monto_stb            in   1              monto/tipo_trans valid
//  balance              out  BAL_W          registered resulting balance
//  balance_actualizado  out  1              1-cycle pulse: balance updated
//  entregar_dinero      out  1              1-cycle pulse: dispense (withdrawal only)
//  pin_incorrecto       out  1              1-cycle pulse: wrong PIN
//  advertencia          out  1              level: one attempt left
//  bloqueo              out  1              level: machine locked until reset
//  fondos_insuficientes out  1              1-cycle pulse: withdrawal > balance
//  desborde             out  1              1-cycle pulse: deposit would overflow BAL_W
// BEHAVIOUR
//  Reset: all outputs 0, balance=0, state IDLE, attempts=0, digit count=0, timer=0.
//  States: IDLE, PIN_ENTRADA, PIN_CHECK, ESPERA_MONTO, TRANSACCION, BLOQUEADO.
//  IDLE: tarjeta_recibida=1 at edge -> latch balance_inicial, clear digits/timer, go PIN_ENTRADA.
//   Strobes are ignored in IDLE.
//  PIN_ENTRADA: each digito_stb with digito<=9 shifts the nibble in (MS first) and restarts the timer.
//   digito>9 is ignored and does not restart the timer. The edge capturing digit N_DIGITOS goes to PIN_CHECK.
//  PIN_CHECK (exactly 1 cycle): compare against pin, result registered at the next edge.
//   Match: attempts=0, advertencia=0, go ESPERA_MONTO.
//   Mismatch: attempts+1, pin_incorrecto pulse, clear digits, go PIN_ENTRADA.
//    If attempts becomes MAX_INTENTOS-1: advertencia=1.
//    If attempts becomes MAX_INTENTOS: bloqueo=1, advertencia=0, attempts=0, go BLOQUEADO
//     (no pin_incorrecto pulse).
//  Latency: last digit edge E -> pin_incorrecto high in the cycle after edge E+1.
//  ESPERA_MONTO: monto_stb -> latch monto/tipo_trans, go TRANSACCION. monto_stb outside this state is ignored.
//  TRANSACCION (1 cycle), registered at the next edge, then go IDLE:
//   deposito: bal+monto>2^BAL_W-1 -> desborde pulse, balance unchanged;
//    else balance=bal+monto, balance_actualizado pulse.
//   retiro: monto>bal -> fondos_insuficientes pulse;
//    else balance=bal-monto, balance_actualizado and entregar_dinero pulses.
//    monto==bal is allowed and yields 0. monto=0 is a valid no-op update.
//  Timeout: TIMEOUT_CICLOS consecutive cycles without an accepted strobe in PIN_ENTRADA or ESPERA_MONTO
//   -> IDLE, digits cleared. Attempts are kept and advertencia stays.
//  Attempts persist across sessions and clear only on a correct PIN, on lock, or on reset.
//  BLOQUEADO: absorbing; bloqueo=1 and all inputs ignored until reset.
//  Reset mid-operation: immediate return to the reset state (clears bloqueo and attempts).
// STRUCTURE
//  cajero_pkg: one-hot state localparams, DEPOSITO=1'b0/RETIRO=1'b1, BCD_MAX=4'd9.
//  Sub-module cajero_pin_entrada: digit shift register, digit counter, timeout counter.
//   Outputs: pin_completo, pin_valor, timeout. Inputs: start/clear, digito_stb, digito.
//  Top holds the FSM, attempt counter and BAL_W+1-bit arithmetic for overflow detection.
// TESTING (N_DIGITOS=4, MAX_INTENTOS=3, BAL_W=16, MONTO_W=8, TIMEOUT_CICLOS=16)
//  pin=16'h1234, digits 1,2,3,4, retiro monto=100 bal=500
//   -> balance=400, balance_actualizado+entregar_dinero 1 cycle.
//  Wrong PIN 1,1,1,1 twice -> 2 pin_incorrecto pulses, advertencia=1 after 2nd.
//   Third wrong -> bloqueo=1 held, all inputs ignored; reset -> bloqueo=0.
//  bal=16'hFFF0, deposito monto=8'h20 -> desborde pulse, balance=16'hFFF0.
//   Deposit 8'h0F -> balance=16'hFFFF.
//  bal=50, retiro monto=51 -> fondos_insuficientes pulse, no dispense.
//   retiro monto=50 -> balance=0, entregar_dinero.
//  Enter 2 digits then 16 idle cycles -> IDLE, attempts unchanged.
//   digito=4'hA mid-PIN is ignored; 1 wrong PIN + timeout + new card + 1 wrong -> advertencia=1.
//  Assert reset during PIN_CHECK and TRANSACCION -> all outputs 0 on the same cycle, state IDLE.

Source files
------------

// File: rtl/cajero_pkg.sv
// cajero_pkg: shared state encoding, transaction types and BCD limit for the ATM controller.
package cajero_pkg;
    typedef enum logic [5:0] {
        IDLE         = 6'b000001,
        PIN_ENTRADA  = 6'b000010,
        PIN_CHECK    = 6'b000100,
        ESPERA_MONTO = 6'b001000,
        TRANSACCION  = 6'b010000,
        BLOQUEADO    = 6'b100000
    } estado_t;
    localparam logic DEPOSITO = 1'b0;
    localparam logic RETIRO = 1'b1;
    localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/cajero_pin_entrada.sv
// cajero_pin_entrada: BCD digit shift register, digit counter and inactivity timer.
module cajero_pin_entrada import cajero_pkg::*; #(
    parameter int N_DIGITOS = 4,
    parameter int TIMEOUT_CICLOS = 1024
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   cuenta_i,
    input  logic                   digito_stb_i,
    input  logic [3:0]             digito_i,
    output logic                   pin_completo_o,
    output logic [4*N_DIGITOS-1:0] pin_valor_o,
    output logic                   timeout_o
);
    localparam int CW = $clog2(N_DIGITOS + 1);
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [4*N_DIGITOS-1:0] sr_q, sr_d;
    logic acepta;
    assign acepta = digito_stb_i && (digito_i <= BCD_MAX);
    // Clearing only rewinds the counter: N fresh digits always overwrite the whole register.
    always_comb begin
        sr_d  = acepta ? ((sr_q << 4) | (4*N_DIGITOS)'(digito_i)) : sr_q;
        cnt_d = clear_i ? '0 : acepta ? cnt_q + CW'(1) : cnt_q;
        tmr_d = (clear_i || acepta) ? '0 : cuenta_i ? tmr_q + TW'(1) : tmr_q;
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
            tmr_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            tmr_q <= tmr_d;
        end
    end
    assign pin_completo_o = acepta && (cnt_q == CW'(N_DIGITOS - 1));
    assign pin_valor_o    = sr_q;
    assign timeout_o      = !acepta && (tmr_q == TW'(TIMEOUT_CICLOS - 1));
endmodule

// File: rtl/cajero_parametrizado.sv
// cajero_parametrizado: ATM controller FSM with PIN retries, lockout and checked deposit/withdrawal.
module cajero_parametrizado import cajero_pkg::*; #(
    parameter int N_DIGITOS = 4,
    parameter int MAX_INTENTOS = 3,
    parameter int BAL_W = 64,
    parameter int MONTO_W = 32,
    parameter int TIMEOUT_CICLOS = 1024
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   tarjeta_recibida_i,
    input  logic                   tipo_trans_i,
    input  logic                   digito_stb_i,
    input  logic [3:0]             digito_i,
    input  logic [4*N_DIGITOS-1:0] pin_i,
    input  logic [BAL_W-1:0]       balance_inicial_i,
    input  logic [MONTO_W-1:0]     monto_i,
    input  logic                   monto_stb_i,
    output logic [BAL_W-1:0]       balance_o,
    output logic                   balance_actualizado_o,
    output logic                   entregar_dinero_o,
    output logic                   pin_incorrecto_o,
    output logic                   advertencia_o,
    output logic                   bloqueo_o,
    output logic                   fondos_insuficientes_o,
    output logic                   desborde_o
);
    localparam int IW = $clog2(MAX_INTENTOS + 1);
    estado_t estado_q, estado_d;
    logic [IW-1:0] intentos_q, intentos_d, intentos_inc;
    logic [BAL_W-1:0] bal_q, bal_d, balance_q, balance_d, monto_ext;
    logic [MONTO_W-1:0] monto_q, monto_d;
    logic [BAL_W:0] suma;
    logic tipo_q, tipo_d, act_q, act_d, ent_q, ent_d, pinc_q, pinc_d;
    logic adv_q, adv_d, blq_q, blq_d, fi_q, fi_d, des_q, des_d;
    logic en_pin, en_monto, pin_completo, timeout;
    logic [4*N_DIGITOS-1:0] pin_valor;
    assign en_pin       = estado_q == PIN_ENTRADA;
    assign en_monto     = estado_q == ESPERA_MONTO;
    assign intentos_inc = intentos_q + IW'(1);
    assign monto_ext    = BAL_W'(monto_q);
    assign suma         = {1'b0, bal_q} + (BAL_W+1)'(monto_q);
    // Every state change restarts the digit count and the inactivity timer.
    cajero_pin_entrada #(.N_DIGITOS(N_DIGITOS), .TIMEOUT_CICLOS(TIMEOUT_CICLOS)) u_pin (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .clear_i       (estado_d != estado_q),
        .cuenta_i      (en_pin || en_monto),
        .digito_stb_i  (digito_stb_i && en_pin),
        .digito_i      (digito_i),
        .pin_completo_o(pin_completo),
        .pin_valor_o   (pin_valor),
        .timeout_o     (timeout)
    );
    always_comb begin
        estado_d   = estado_q;
        intentos_d = intentos_q;
        bal_d      = bal_q;
        balance_d  = balance_q;
        monto_d    = monto_q;
        tipo_d     = tipo_q;
        adv_d      = adv_q;
        blq_d      = blq_q;
        act_d      = 1'b0;
        ent_d      = 1'b0;
        pinc_d     = 1'b0;
        fi_d       = 1'b0;
        des_d      = 1'b0;
        unique case (estado_q)
            IDLE: if (tarjeta_recibida_i) begin
                bal_d    = balance_inicial_i;
                estado_d = PIN_ENTRADA;
            end
            PIN_ENTRADA: estado_d = pin_completo ? PIN_CHECK : timeout ? IDLE : PIN_ENTRADA;
            PIN_CHECK: if (pin_valor == pin_i) begin
                intentos_d = '0;
                adv_d      = 1'b0;
                estado_d   = ESPERA_MONTO;
            end else if (intentos_inc == IW'(MAX_INTENTOS)) begin
                intentos_d = '0;
                adv_d      = 1'b0;
                blq_d      = 1'b1;
                estado_d   = BLOQUEADO;
            end else begin
                intentos_d = intentos_inc;
                adv_d      = adv_q || (intentos_inc == IW'(MAX_INTENTOS - 1));
                pinc_d     = 1'b1;
                estado_d   = PIN_ENTRADA;
            end
            ESPERA_MONTO: if (monto_stb_i) begin
                monto_d  = monto_i;
                tipo_d   = tipo_trans_i;
                estado_d = TRANSACCION;
            end else if (timeout) begin
                estado_d = IDLE;
            end
            TRANSACCION: begin
                estado_d = IDLE;
                if (tipo_q == DEPOSITO) begin
                    des_d     = suma[BAL_W];
                    act_d     = !suma[BAL_W];
                    balance_d = suma[BAL_W] ? bal_q : suma[BAL_W-1:0];
                end else begin
                    fi_d      = monto_ext > bal_q;
                    act_d     = !fi_d;
                    ent_d     = !fi_d;
                    balance_d = fi_d ? bal_q : bal_q - monto_ext;
                end
            end
            BLOQUEADO: estado_d = BLOQUEADO;
            default: estado_d = IDLE;
        endcase
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            estado_q   <= IDLE;
            intentos_q <= '0;
            bal_q      <= '0;
            balance_q  <= '0;
            monto_q    <= '0;
            tipo_q     <= 1'b0;
            act_q      <= 1'b0;
            ent_q      <= 1'b0;
            pinc_q     <= 1'b0;
            adv_q      <= 1'b0;
            blq_q      <= 1'b0;
            fi_q       <= 1'b0;
            des_q      <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            intentos_q <= intentos_d;
            bal_q      <= bal_d;
            balance_q  <= balance_d;
            monto_q    <= monto_d;
            tipo_q     <= tipo_d;
            act_q      <= act_d;
            ent_q      <= ent_d;
            pinc_q     <= pinc_d;
            adv_q      <= adv_d;
            blq_q      <= blq_d;
            fi_q       <= fi_d;
            des_q      <= des_d;
        end
    end
    assign balance_o              = balance_q;
    assign balance_actualizado_o  = act_q;
    assign entregar_dinero_o      = ent_q;
    assign pin_incorrecto_o       = pinc_q;
    assign advertencia_o          = adv_q;
    assign bloqueo_o              = blq_q;
    assign fondos_insuficientes_o = fi_q;
    assign desborde_o             = des_q;
endmodule

// File: tb/tb_cajero_parametrizado.sv
// tb_cajero_parametrizado: vector table, directed corner sequences and random sessions
// checked against a session-level model of the ATM rules.
module tb_cajero_parametrizado;
    localparam int MAXI = 3;
    localparam int TO = 16;
    logic clock = 1'b0, reset = 1'b1, tarjeta = 1'b0, tipo = 1'b0, dstb = 1'b0, mstb = 1'b0;
    logic [3:0] digito = '0;
    logic [15:0] pin = 16'h1234, bal_ini = '0, balance;
    logic [7:0] monto = '0;
    logic act, ent, pinc, adv, blq, fi, des;
    int compared = 0, mismatched = 0;

    typedef struct {
        logic [15:0] bal;
        logic        t;
        logic [7:0]  m;
        logic [15:0] eb;
        logic        ea, ee, ef, ed;
    } vec_t;
    vec_t tabla[8];

    always #5 clock = ~clock;

    cajero_parametrizado #(.N_DIGITOS(4), .MAX_INTENTOS(MAXI), .BAL_W(16), .MONTO_W(8),
                           .TIMEOUT_CICLOS(TO)) dut (
        .clock_i(clock), .reset_i(reset), .tarjeta_recibida_i(tarjeta), .tipo_trans_i(tipo),
        .digito_stb_i(dstb), .digito_i(digito), .pin_i(pin), .balance_inicial_i(bal_ini),
        .monto_i(monto), .monto_stb_i(mstb), .balance_o(balance), .balance_actualizado_o(act),
        .entregar_dinero_o(ent), .pin_incorrecto_o(pinc), .advertencia_o(adv), .bloqueo_o(blq),
        .fondos_insuficientes_o(fi), .desborde_o(des)
    );

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic tarjeta_in(input logic [15:0] b);
        tarjeta = 1'b1; bal_ini = b; tick(); tarjeta = 1'b0;
    endtask

    task automatic uno(input logic [3:0] d);
        dstb = 1'b1; digito = d; tick(); dstb = 1'b0;
    endtask

    task automatic digitos(input logic [15:0] d);
        for (int i = 3; i >= 0; i--) uno(d[4*i +: 4]);
    endtask

    task automatic operar(input logic t, input logic [7:0] m);
        tipo = t; monto = m; mstb = 1'b1; tick(); mstb = 1'b0; tick();
    endtask

    task automatic chk_tx(input string nm, input logic [15:0] eb, input logic ea, ee, ef, ed);
        chk({nm, ".balance"}, balance, eb);
        chk({nm, ".actualizado"}, act, ea);
        chk({nm, ".entregar"}, ent, ee);
        chk({nm, ".fondos"}, fi, ef);
        chk({nm, ".desborde"}, des, ed);
    endtask

    task automatic reiniciar();
        reset = 1'b1; tick(); reset = 1'b0; tick();
    endtask

    function automatic logic [15:0] pin_azar();
        logic [15:0] p;
        for (int i = 0; i < 4; i++) p[4*i +: 4] = 4'($urandom_range(0, 9));
        return p;
    endfunction

    function automatic logic [15:0] pin_malo(input logic [15:0] p);
        logic [15:0] w = pin_azar();
        if (w == p) w[3:0] = (w[3:0] == 4'd9) ? 4'd0 : w[3:0] + 4'd1;
        return w;
    endfunction

    initial begin
        logic [15:0] b, eb;
        logic [7:0] m;
        logic t, ok, done, ea, ee, ef, ed;
        int m_int;
        longint s;
        tabla[0] = '{16'd500,   1'b1, 8'd100,  16'd400,   1'b1, 1'b1, 1'b0, 1'b0};
        tabla[1] = '{16'hFFF0,  1'b0, 8'h20,   16'hFFF0,  1'b0, 1'b0, 1'b0, 1'b1};
        tabla[2] = '{16'hFFF0,  1'b0, 8'h0F,   16'hFFFF,  1'b1, 1'b0, 1'b0, 1'b0};
        tabla[3] = '{16'd50,    1'b1, 8'd51,   16'd50,    1'b0, 1'b0, 1'b1, 1'b0};
        tabla[4] = '{16'd50,    1'b1, 8'd50,   16'd0,     1'b1, 1'b1, 1'b0, 1'b0};
        tabla[5] = '{16'd123,   1'b1, 8'd0,    16'd123,   1'b1, 1'b1, 1'b0, 1'b0};
        tabla[6] = '{16'hFFFF,  1'b0, 8'd1,    16'hFFFF,  1'b0, 1'b0, 1'b0, 1'b1};
        tabla[7] = '{16'hFF00,  1'b0, 8'hFF,   16'hFFFF,  1'b1, 1'b0, 1'b0, 1'b0};

        tick(2);
        chk("reset.balance", balance, 0);
        chk("reset.pulsos", {act, ent, pinc, fi, des}, 0);
        chk("reset.niveles", {adv, blq}, 0);
        reset = 1'b0; tick();

        foreach (tabla[i]) begin
            tarjeta_in(tabla[i].bal);
            digitos(16'h1234); tick();
            chk("tabla.pin_ok", pinc, 0);
            operar(tabla[i].t, tabla[i].m);
            chk_tx($sformatf("tabla%0d", i), tabla[i].eb, tabla[i].ea, tabla[i].ee, tabla[i].ef, tabla[i].ed);
            tick();
            chk("tabla.pulso", {act, ent, fi, des}, 0);
        end

        // Three wrong PINs in one session lock the machine.
        tarjeta_in(16'd500);
        digitos(16'h1111);
        chk("latencia.pinc", pinc, 0);
        tick();
        chk("malo1.pinc", pinc, 1); chk("malo1.adv", adv, 0);
        tick();
        chk("malo1.pulso", pinc, 0);
        digitos(16'h1111); tick();
        chk("malo2.pinc", pinc, 1); chk("malo2.adv", adv, 1);
        digitos(16'h1111); tick();
        chk("malo3.pinc", pinc, 0); chk("malo3.blq", blq, 1); chk("malo3.adv", adv, 0);
        tarjeta = 1'b1; tick(); tarjeta = 1'b0;
        digitos(16'h1234); operar(1'b0, 8'd5); tick(10);
        chk("bloqueado.blq", blq, 1);
        chk("bloqueado.salidas", {act, ent, pinc, fi, des, adv}, 0);
        reset = 1'b1; #1;
        chk("bloqueado.reset", blq, 0);
        tick(); reset = 1'b0; tick();

        // Timeout boundary: 15 idle cycles survive, 16 abort the session.
        tarjeta_in(16'd300); uno(4'd1); uno(4'd2); tick(TO - 1); uno(4'd3); uno(4'd4); tick();
        operar(1'b0, 8'd5);
        chk_tx("espera15", 16'd305, 1'b1, 1'b0, 1'b0, 1'b0);
        tarjeta_in(16'd300); uno(4'd1); uno(4'd2); tick(TO); uno(4'd3); uno(4'd4); tick();
        operar(1'b0, 8'd5);
        chk("espera16.act", act, 0);
        chk("espera16.balance", balance, 16'd305);
        tarjeta_in(16'd300); digitos(16'h1234); tick(); operar(1'b0, 8'd7);
        chk_tx("tras_timeout", 16'd307, 1'b1, 1'b0, 1'b0, 1'b0);

        // Non-BCD digit is ignored mid-PIN.
        tarjeta_in(16'd10); uno(4'd1); uno(4'hA); uno(4'd2); uno(4'd3); uno(4'd4); tick();
        chk("hex.pinc", pinc, 0);
        operar(1'b0, 8'd1);
        chk_tx("hex", 16'd11, 1'b1, 1'b0, 1'b0, 1'b0);

        // Attempts survive a timeout and a new card.
        tarjeta_in(16'd0); digitos(16'h1111); tick();
        chk("persist1.pinc", pinc, 1); chk("persist1.adv", adv, 0);
        tick(TO);
        tarjeta_in(16'd0); digitos(16'h9999); tick();
        chk("persist2.pinc", pinc, 1); chk("persist2.adv", adv, 1);
        digitos(16'h1234); tick();
        chk("persist_ok.adv", adv, 0);
        operar(1'b0, 8'd0);
        chk_tx("deposito_cero", 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset during PIN_CHECK and TRANSACCION.
        tarjeta_in(16'd0); digitos(16'h1111); tick(); digitos(16'h1111); tick();
        chk("pre_reset.adv", adv, 1);
        digitos(16'h1111);
        reset = 1'b1; #1;
        chk("reset_check.niveles", {adv, blq, pinc}, 0);
        tick();
        chk("reset_check.tras", {adv, blq, pinc}, 0);
        reset = 1'b0; tick();
        tarjeta_in(16'd1000); digitos(16'h1234); tick(); operar(1'b0, 8'd5);
        chk("pre_reset.balance", balance, 16'd1005);
        tarjeta_in(16'd1000); digitos(16'h1234); tick();
        tipo = 1'b0; monto = 8'd5; mstb = 1'b1; tick(); mstb = 1'b0;
        reset = 1'b1; #1;
        chk("reset_tx.balance", balance, 0);
        chk("reset_tx.pulsos", {act, ent, fi, des}, 0);
        tick();
        chk("reset_tx.tras", {balance, act}, 0);
        reset = 1'b0; tick();

        // Random sessions against a session-level model.
        m_int = 0;
        for (int n = 0; n < 40; n++) begin
            b = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 300)) : 16'($urandom_range(0, 400));
            pin = pin_azar();
            tarjeta_in(b);
            done = 1'b0;
            while (!done) begin
                ok = $urandom_range(0, 2) != 0;
                digitos(ok ? pin : pin_malo(pin)); tick();
                if (ok) begin
                    m_int = 0;
                    chk("rnd.pinc_ok", pinc, 0); chk("rnd.adv_ok", adv, 0);
                    t = 1'($urandom_range(0, 1)); m = 8'($urandom);
                    operar(t, m);
                    s = t ? longint'(b) - longint'(m) : longint'(b) + longint'(m);
                    ef = t && s < 0;
                    ed = !t && s > 65535;
                    ea = !ef && !ed;
                    ee = t && ea;
                    eb = ea ? 16'(s) : b;
                    chk_tx("rnd", eb, ea, ee, ef, ed);
                    done = 1'b1;
                end else begin
                    m_int++;
                    if (m_int == MAXI) begin
                        chk("rnd.blq", blq, 1); chk("rnd.pinc_blq", pinc, 0);
                        m_int = 0;
                        reiniciar();
                        chk("rnd.blq_reset", blq, 0);
                        done = 1'b1;
                    end else begin
                        chk("rnd.pinc", pinc, 1); chk("rnd.adv", adv, 32'(m_int == MAXI - 1));
                        if ($urandom_range(0, 3) == 0) begin
                            tick(TO);
                            done = 1'b1;
                        end
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
